// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Two-requester req/ack arbiter in front of a single-port RAM,
//            one registered transaction in flight at a time.
// Options  : ARB_ROUND_ROBIN_EN selects round-robin conflict resolution;
//            undefined gives fixed priority to port 0.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam logic [2:0] c_wait_init = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_cnt;
    logic       r_last_grant;
    logic       w_winner;

    // Arbitration: a lone requester always wins; only conflicts use the policy.
    always_comb begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_winner = ~r_last_grant;
`else
            w_winner = 1'b0;
`endif
        end else begin
            w_winner = req1;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In ACCESS, ram_we still holds the latched direction of the transaction.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (req0 || req1) w_next_state = ACCESS;
            ACCESS:  w_next_state = ram_we ? DONE : WAIT;
            WAIT:    if (r_cnt == 3'd0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Every output is registered from the upcoming state, so each is visible
    // in the cycle the FSM occupies that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= 3'd0;
            r_last_grant <= 1'b1;
            grant_id     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            busy   <= (w_next_state != IDLE);
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_id  <= w_winner;
                        ram_en    <= 1'b1;
                        ram_we    <= w_winner ? we1 : we0;
                        ram_addr  <= w_winner ? addr1 : addr0;
                        ram_wdata <= w_winner ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    if (ram_we) begin
                        ack0 <= ~grant_id;
                        ack1 <= grant_id;
                    end else begin
                        r_cnt <= c_wait_init;
                    end
                end
                WAIT: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        if (grant_id) begin
                            rdata1 <= ram_rdata;
                        end else begin
                            rdata0 <= ram_rdata;
                        end
                        ack0 <= ~grant_id;
                        ack1 <= grant_id;
                    end
                end
                DONE: begin
                    r_last_grant <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
